// File: rtl/edp_muldiv_seq.sv
// ============================================================================
// edp_muldiv_seq
// ----------------------------------------------------------------------------
// Iterative unsigned multiply / divide sequencer for the EBOX data path.
// One multiply or divide step is taken per EDP clock on AR/MQ/BR-style
// registers (ACC, MQ, BR), so microcode only has to issue start and collect
// the result on done.
//
//   multiply : shift-and-add, {ACC,MQ} ends up holding the 2*WIDTH product
//   divide   : restoring division of {a_hi,a_lo} by b,
//              MQ = quotient, ACC = remainder
//
// Bit numbering follows the EBOX convention [0:WIDTH-1], bit 0 = MSB, so
// MQ[WIDTH-1] is the multiplier bit consumed next.
//
// Parameters
//   WIDTH   operand width in bits
//   CNT_W   step-counter width, 2**CNT_W must exceed WIDTH
//
// Ports
//   CLK_EDP   in   EDP clock, rising edge
//   CROBAR_N  in   asynchronous active-low reset
//   start     in   begin an operation (sampled only while busy=0)
//   abort     in   cancel a running operation (no done, results unchanged)
//   op        in   0 = multiply, 1 = divide (sampled with start)
//   a_hi      in   dividend high word (unused for multiply)
//   a_lo      in   multiplier / dividend low word
//   b         in   multiplicand / divisor
//   busy      out  operation in progress
//   done      out  one-cycle result-valid pulse
//   ovf       out  divide overflow, valid with done, held until next start
//   res_hi    out  product high word / remainder
//   res_lo    out  product low word / quotient
//   steps     out  steps remaining, 0 when idle
//
// Build option
//   EDP_MULDIV_EARLY_EXIT_EN : when defined, a multiply finishes as soon as
//   the multiplier bits still to be consumed are all zero; the remaining
//   shifts are applied in one go. Divide timing is unaffected. When the
//   macro is undefined every multiply takes exactly WIDTH steps.
// ============================================================================
module edp_muldiv_seq #(
    parameter int WIDTH = 36,
    parameter int CNT_W = 6
) (
    input  logic             CLK_EDP,
    input  logic             CROBAR_N,
    input  logic             start,
    input  logic             abort,
    input  logic             op,
    input  logic [0:WIDTH-1] a_hi,
    input  logic [0:WIDTH-1] a_lo,
    input  logic [0:WIDTH-1] b,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [0:WIDTH-1] res_hi,
    output logic [0:WIDTH-1] res_lo,
    output logic [CNT_W-1:0] steps
);

    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Working registers (data path, no reset needed: always loaded on start)
    logic [0:WIDTH-1] acc;
    logic [0:WIDTH-1] mq;
    logic [0:WIDTH-1] br;
    logic             op_run;

    logic [0:WIDTH-1] acc_next;
    logic [0:WIDTH-1] mq_next;
    logic [0:WIDTH-1] br_next;
    logic             op_run_next;

    // Registered outputs
    logic             done_next;
    logic             ovf_next;
    logic [0:WIDTH-1] res_hi_next;
    logic [0:WIDTH-1] res_lo_next;
    logic [CNT_W-1:0] steps_next;

    // ------------------------------------------------------------------
    // Multiply step: conditionally add BR, then shift {sum,MQ} right by
    // one. The sum is WIDTH+1 bits so its carry lands in ACC[0].
    // ------------------------------------------------------------------
    logic [0:WIDTH]   mul_sum;
    logic [0:WIDTH-1] mul_acc;
    logic [0:WIDTH-1] mul_mq;

    always_comb begin
        mul_sum = {1'b0, acc};
        if (mq[WIDTH-1]) begin
            mul_sum = {1'b0, acc} + {1'b0, br};
        end
        mul_acc = mul_sum[0:WIDTH-1];
        mul_mq  = {mul_sum[WIDTH], mq[0:WIDTH-2]};
    end

    // ------------------------------------------------------------------
    // Divide step: trial-subtract BR from {ACC,MQ[0]}. Because ACC < BR
    // is guaranteed (overflow is screened at start), a successful
    // subtraction always fits back into WIDTH bits, so only the low
    // WIDTH bits of the difference are formed.
    // ------------------------------------------------------------------
    logic             div_fits;
    logic [0:WIDTH-1] div_diff;
    logic [0:WIDTH-1] div_acc;
    logic [0:WIDTH-1] div_mq;

    always_comb begin
        div_fits = ({acc, mq[0]} >= {1'b0, br});
        div_diff = {acc[1:WIDTH-1], mq[0]} - br;
        if (div_fits) begin
            div_acc = div_diff;
            div_mq  = {mq[1:WIDTH-1], 1'b1};
        end else begin
            div_acc = {acc[1:WIDTH-1], mq[0]};
            div_mq  = {mq[1:WIDTH-1], 1'b0};
        end
    end

    // Quotient would not fit in WIDTH bits (also catches b = 0)
    logic div_ovf;
    assign div_ovf = (a_hi >= b);

    // ------------------------------------------------------------------
    // Multiply finish values. fin_acc/fin_mq are what {ACC,MQ} becomes on
    // this RUN edge; mul_early says the multiply may end on this edge.
    // ------------------------------------------------------------------
    logic             mul_early;
    logic [0:WIDTH-1] fin_acc;
    logic [0:WIDTH-1] fin_mq;

`ifdef EDP_MULDIV_EARLY_EXIT_EN
    // After this step, the low (steps-1) bits of MQ are the multiplier
    // bits not yet consumed. If they are all zero the remaining steps
    // would only shift, so apply that shift now and finish.
    logic [CNT_W-1:0]   pend_cnt;
    logic [0:WIDTH-1]   pend_mask;
    logic [0:2*WIDTH-1] fin_prod;

    always_comb begin
        pend_cnt  = steps - STEP_ONE;
        pend_mask = ~({WIDTH{1'b1}} << pend_cnt);
        mul_early = ((mul_mq & pend_mask) == '0);
        fin_prod  = {mul_acc, mul_mq} >> pend_cnt;
        fin_acc   = fin_prod[0:WIDTH-1];
        fin_mq    = fin_prod[WIDTH:2*WIDTH-1];
    end
`else
    assign mul_early = 1'b0;
    assign fin_acc   = mul_acc;
    assign fin_mq    = mul_mq;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        acc_next    = acc;
        mq_next     = mq;
        br_next     = br;
        op_run_next = op_run;
        steps_next  = steps;
        done_next   = 1'b0;
        ovf_next    = ovf;
        res_hi_next = res_hi;
        res_lo_next = res_lo;

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_run_next = op;
                    acc_next    = op ? a_hi : '0;
                    mq_next     = a_lo;
                    br_next     = b;
                    ovf_next    = 1'b0;
                    if (op && div_ovf) begin
                        // Overflowed divide: no steps, operands returned
                        done_next   = 1'b1;
                        ovf_next    = 1'b1;
                        res_hi_next = a_hi;
                        res_lo_next = a_lo;
                    end else begin
                        state_next = S_RUN;
                        steps_next = STEP_LOAD;
                    end
                end
            end

            S_RUN: begin
                if (abort) begin
                    state_next = S_IDLE;
                    steps_next = '0;
                end else if (op_run) begin
                    acc_next   = div_acc;
                    mq_next    = div_mq;
                    steps_next = steps - STEP_ONE;
                    if (steps == STEP_ONE) begin
                        state_next  = S_IDLE;
                        done_next   = 1'b1;
                        res_hi_next = div_acc;
                        res_lo_next = div_mq;
                    end
                end else begin
                    acc_next   = fin_acc;
                    mq_next    = fin_mq;
                    steps_next = steps - STEP_ONE;
                    if (mul_early || (steps == STEP_ONE)) begin
                        state_next  = S_IDLE;
                        steps_next  = '0;
                        done_next   = 1'b1;
                        res_hi_next = fin_acc;
                        res_lo_next = fin_mq;
                    end
                end
            end

            default: begin
                state_next = S_IDLE;
                steps_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_EDP or negedge CROBAR_N) begin
        if (!CROBAR_N) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            ovf    <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
            steps  <= '0;
        end else begin
            state  <= state_next;
            done   <= done_next;
            ovf    <= ovf_next;
            res_hi <= res_hi_next;
            res_lo <= res_lo_next;
            steps  <= steps_next;
        end
    end

    // Working registers
    always_ff @(posedge CLK_EDP) begin
        acc    <= acc_next;
        mq     <= mq_next;
        br     <= br_next;
        op_run <= op_run_next;
    end

    assign busy = (state == S_RUN);

endmodule

// File: tb/tb_edp_muldiv_seq.sv
// ============================================================================
// tb_edp_muldiv_seq
// Table-driven bench for edp_muldiv_seq with a scoreboard queue: expected
// results are pushed when an operation is accepted and popped when done
// pulses. Hand-written sequences cover abort, start while busy, start on the
// done cycle, divide overflow and reset in the middle of an operation.
// ============================================================================
module tb_edp_muldiv_seq;

    localparam int W  = 36;
    localparam int CW = 6;

`ifdef EDP_MULDIV_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          op    = 1'b0;
    logic [W-1:0]  a_hi  = '0;
    logic [W-1:0]  a_lo  = '0;
    logic [W-1:0]  b     = '0;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [W-1:0]  res_hi;
    logic [W-1:0]  res_lo;
    logic [CW-1:0] steps;

    edp_muldiv_seq #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK_EDP (clk),
        .CROBAR_N(rst_n),
        .start   (start),
        .abort   (abort),
        .op      (op),
        .a_hi    (a_hi),
        .a_lo    (a_lo),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .res_hi  (res_hi),
        .res_lo  (res_lo),
        .steps   (steps)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a_hi;
        logic [W-1:0] a_lo;
        logic [W-1:0] b;
        logic [W-1:0] e_hi;
        logic [W-1:0] e_lo;
        logic         e_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
        int           lat;
        int           acc_cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks   = 0;
    int           errors   = 0;
    int           cyc      = 0;
    int           done_cnt = 0;
    logic [W-1:0] last_hi  = '0;
    logic [W-1:0] last_lo  = '0;
    logic         last_ovf = 1'b0;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int bitlen(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [W-1:0] rnd36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // Reference model: plain wide arithmetic
    function automatic vec_t mkv(input logic o, input logic [W-1:0] ah, input logic [W-1:0] al,
                                 input logic [W-1:0] bb);
        vec_t           v;
        logic [2*W-1:0] p;
        logic [2*W-1:0] dvd;
        logic [2*W-1:0] dvs;
        v.op = o; v.a_hi = ah; v.a_lo = al; v.b = bb;
        if (!o) begin
            p       = {{W{1'b0}}, al} * {{W{1'b0}}, bb};
            v.e_hi  = W'(p >> W);
            v.e_lo  = W'(p);
            v.e_ovf = 1'b0;
        end else if (ah >= bb) begin
            v.e_hi  = ah;
            v.e_lo  = al;
            v.e_ovf = 1'b1;
        end else begin
            dvd     = {ah, al};
            dvs     = {{W{1'b0}}, bb};
            v.e_lo  = W'(dvd / dvs);
            v.e_hi  = W'(dvd % dvs);
            v.e_ovf = 1'b0;
        end
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
        int n;
        if (v.op && (v.a_hi >= v.b)) return 1;
        if (!v.op && EE) begin
            n = bitlen(v.a_lo);
            if (n < 1) n = 1;
            return n + 1;
        end
        return W + 1;
    endfunction

    // Drive one start pulse; the DUT is expected to be idle at the next edge
    task automatic issue(input vec_t v, input bit push);
        exp_t e;
        op    = v.op;
        a_hi  = v.a_hi;
        a_lo  = v.a_lo;
        b     = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.hi      = v.e_hi;
            e.lo      = v.e_lo;
            e.ovf     = v.e_ovf;
            e.lat     = exp_lat(v);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                chk("res_hi", 72'(res_hi), 72'(mon_e.hi));
                chk("res_lo", 72'(res_lo), 72'(mon_e.lo));
                chk("ovf", 72'(ovf), 72'(mon_e.ovf));
                chk("latency", 72'(cyc + 1 - mon_e.acc_cyc), 72'(mon_e.lat));
                chk("busy_at_done", 72'(busy), 72'd0);
                last_hi  = mon_e.hi;
                last_lo  = mon_e.lo;
                last_ovf = mon_e.ovf;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[12];
    vec_t va;
    vec_t vb;
    int   n;
    int   dc;

    initial begin
        logic [W-1:0] rb;
        vecs[0] = '{1'b0, 36'd0, 36'd3,   36'd5, 36'd0,              36'd15,  1'b0};
        vecs[1] = '{1'b0, 36'd0, ONES,    ONES,  36'o777777777776,   36'd1,   1'b0};
        vecs[2] = '{1'b1, 36'd0, 36'd100, 36'd7, 36'd2,              36'd14,  1'b0};
        vecs[3] = '{1'b1, 36'd0, 36'd100, 36'd0, 36'd0,              36'd100, 1'b1};
        vecs[4] = '{1'b0, 36'd0, 36'd1,   36'd9, 36'd0,              36'd9,   1'b0};
        vecs[5] = '{1'b1, 36'd5, 36'd7,   36'd5, 36'd5,              36'd7,   1'b1};
        vecs[6] = '{1'b0, 36'd0, 36'd0,   ONES,  36'd0,              36'd0,   1'b0};
        vecs[7] = '{1'b1, 36'd6, ONES,    36'd7, 36'd6,              ONES,    1'b0};
        vecs[8]  = mkv(1'b0, 36'd0, rnd36(), rnd36());
        vecs[9]  = mkv(1'b0, 36'd0, rnd36() >> 20, rnd36());
        rb = rnd36() | 36'd1;
        vecs[10] = mkv(1'b1, rnd36() % rb, rnd36(), rb);
        rb = (rnd36() >> 18) | 36'd1;
        vecs[11] = mkv(1'b1, rnd36() % rb, rnd36(), rb);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",   72'(busy),   72'd0);
        chk("rst_done",   72'(done),   72'd0);
        chk("rst_ovf",    72'(ovf),    72'd0);
        chk("rst_res_hi", 72'(res_hi), 72'd0);
        chk("rst_res_lo", 72'(res_lo), 72'd0);
        chk("rst_steps",  72'(steps),  72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i], 1'b1);
            wait_drain(200);
            @(negedge clk);
        end

        // Abort at steps=10: no done, results unchanged
        va = mkv(1'b0, 36'd0, 36'h8_0000_0003, 36'h123);
        issue(va, 1'b0);
        n = 0;
        while (steps != CW'(10) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_steps10", 72'(steps), 72'd10);
        dc    = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy",   72'(busy),   72'd0);
        chk("abort_steps",  72'(steps),  72'd0);
        chk("abort_res_hi", 72'(res_hi), 72'(last_hi));
        chk("abort_res_lo", 72'(res_lo), 72'(last_lo));
        chk("abort_ovf",    72'(ovf),    72'(last_ovf));
        repeat (40) @(negedge clk);
        chk("abort_no_done", 72'(done_cnt), 72'(dc));
        issue(va, 1'b1);
        wait_drain(200);
        @(negedge clk);

        // Start while busy is ignored
        issue(mkv(1'b0, 36'd0, 36'd12345, 36'd678), 1'b1);
        repeat (3) @(negedge clk);
        chk("busy_running", 72'(busy), 72'd1);
        op    = 1'b1;
        a_hi  = '0;
        a_lo  = 36'd999;
        b     = 36'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_ignored_start", 72'(busy), 72'd1);
        wait_drain(200);
        @(negedge clk);

        // Start on the done cycle is accepted back-to-back
        va = mkv(1'b0, 36'd0, 36'd77, 36'd11);
        vb = mkv(1'b1, 36'd0, 36'd1000, 36'd9);
        issue(va, 1'b1);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", 72'(done), 72'd1);
        issue(vb, 1'b1);
        chk("b2b_busy", 72'(busy), 72'd1);
        wait_drain(200);
        @(negedge clk);

        // Reset in the middle of an operation
        issue(mkv(1'b0, 36'd0, ONES, 36'd5), 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy",   72'(busy),   72'd0);
        chk("mid_rst_done",   72'(done),   72'd0);
        chk("mid_rst_ovf",    72'(ovf),    72'd0);
        chk("mid_rst_res_hi", 72'(res_hi), 72'd0);
        chk("mid_rst_res_lo", 72'(res_lo), 72'd0);
        chk("mid_rst_steps",  72'(steps),  72'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Operation after reset
        issue(vecs[2], 1'b1);
        wait_drain(200);
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
